// File: rtl/fixed_to_float_pipe_if.sv
// Streaming handshake bundle for fixed_to_float_pipe; INEXACT exists only with FIX2FLT_INEXACT_FLAG_EN.
interface fixed_to_float_pipe_if #(
    parameter int IW = 32,
    parameter int EW = 8,
    parameter int MW = 23
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [IW-1:0]   FIXED_IN;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [EW+MW:0]  FLOAT_OUT;
    logic            OVF;
`ifdef FIX2FLT_INEXACT_FLAG_EN
    logic            INEXACT;

    modport slave (
        input  IN_VALID, FIXED_IN, OUT_READY,
        output IN_READY, OUT_VALID, FLOAT_OUT, OVF, INEXACT
    );
    modport master (
        output IN_VALID, FIXED_IN, OUT_READY,
        input  IN_READY, OUT_VALID, FLOAT_OUT, OVF, INEXACT
    );
`else
    modport slave (
        input  IN_VALID, FIXED_IN, OUT_READY,
        output IN_READY, OUT_VALID, FLOAT_OUT, OVF
    );
    modport master (
        output IN_VALID, FIXED_IN, OUT_READY,
        input  IN_READY, OUT_VALID, FLOAT_OUT, OVF
    );
`endif
endinterface

// File: rtl/fixed_to_float_pipe.sv
// Three-stage signed fixed-point to IEEE-754 converter with RNE rounding and valid/ready flow control.
// Optional INEXACT output enabled by defining FIX2FLT_INEXACT_FLAG_EN.
module fixed_to_float_pipe #(
    parameter int IW = 32,
    parameter int FB = 26,
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    fixed_to_float_pipe_if.slave bus
);
    localparam int PW   = $clog2(IW);
    localparam int BIAS = 2**(EW-1) - 1;
    localparam int EXW  = IW + MW + 1;
    localparam logic signed [EW+1:0] EOFF = (EW+2)'(BIAS - FB);
    localparam logic signed [EW+1:0] EMAX = (EW+2)'(2**EW - 1);

    logic            adv;
    logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic            sign1_q, sign1_d, sign2_q, sign2_d;
    logic [IW-1:0]   mag1_q, mag1_d;
    logic [IW-1:0]   norm2_q, norm2_d;
    logic            zero2_q, zero2_d;
    logic [PW-1:0]   p2_q, p2_d;
    logic [EW+MW:0]  float_q, float_d;
    logic            ovf_q, ovf_d;
`ifdef FIX2FLT_INEXACT_FLAG_EN
    logic            inexact_q, inexact_d;
`endif

    logic [PW-1:0]          p_scan;
    logic [EXW-1:0]         ext;
    logic [MW-1:0]          mant;
    logic                   guard, sticky, inc;
    logic [MW:0]            mant_sum;
    logic signed [EW+1:0]   exp_fin;

    always_comb begin
        adv = bus.OUT_READY | ~v3_q;

        v1_d    = v1_q;    sign1_d = sign1_q; mag1_d  = mag1_q;
        v2_d    = v2_q;    sign2_d = sign2_q; zero2_d = zero2_q;
        p2_d    = p2_q;    norm2_d = norm2_q;
        v3_d    = v3_q;    float_d = float_q; ovf_d   = ovf_q;
`ifdef FIX2FLT_INEXACT_FLAG_EN
        inexact_d = inexact_q;
`endif

        p_scan = '0;
        for (int unsigned i = 0; i < IW; i++) begin
            if (mag1_q[i]) p_scan = PW'(i);
        end

        // norm2_q holds the bits below the leading one, MSB-aligned (leading one shifted out)
        ext      = {norm2_q, {(MW+1){1'b0}}};
        mant     = ext[EXW-1 -: MW];
        guard    = ext[EXW-1-MW];
        sticky   = |ext[EXW-2-MW:0];
        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + (MW+1)'(inc);
        exp_fin  = $signed((EW+2)'(p2_q)) + EOFF + $signed((EW+2)'(mant_sum[MW]));

        if (adv) begin
            v1_d    = bus.IN_VALID;
            sign1_d = bus.FIXED_IN[IW-1];
            mag1_d  = bus.FIXED_IN[IW-1] ? -bus.FIXED_IN : bus.FIXED_IN;

            v2_d    = v1_q;
            sign2_d = sign1_q;
            zero2_d = ~|mag1_q;
            p2_d    = p_scan;
            norm2_d = mag1_q << ((PW+1)'(IW) - {1'b0, p_scan});

            v3_d = v2_q;
            if (zero2_q) begin
                float_d = '0;
                ovf_d   = 1'b0;
`ifdef FIX2FLT_INEXACT_FLAG_EN
                inexact_d = 1'b0;
`endif
            end else if (exp_fin >= EMAX) begin
                float_d = {sign2_q, {EW{1'b1}}, {MW{1'b0}}};
                ovf_d   = 1'b1;
`ifdef FIX2FLT_INEXACT_FLAG_EN
                inexact_d = 1'b1;
`endif
            end else if (exp_fin[EW+1] || exp_fin == '0) begin
                float_d = {sign2_q, {(EW+MW){1'b0}}};
                ovf_d   = 1'b0;
`ifdef FIX2FLT_INEXACT_FLAG_EN
                inexact_d = 1'b1;
`endif
            end else begin
                float_d = {sign2_q, exp_fin[EW-1:0], mant_sum[MW-1:0]};
                ovf_d   = 1'b0;
`ifdef FIX2FLT_INEXACT_FLAG_EN
                inexact_d = guard | sticky;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1_q    <= 1'b0; sign1_q <= 1'b0; mag1_q  <= '0;
            v2_q    <= 1'b0; sign2_q <= 1'b0; zero2_q <= 1'b0;
            p2_q    <= '0;   norm2_q <= '0;
            v3_q    <= 1'b0; float_q <= '0;   ovf_q   <= 1'b0;
`ifdef FIX2FLT_INEXACT_FLAG_EN
            inexact_q <= 1'b0;
`endif
        end else begin
            v1_q    <= v1_d;    sign1_q <= sign1_d; mag1_q  <= mag1_d;
            v2_q    <= v2_d;    sign2_q <= sign2_d; zero2_q <= zero2_d;
            p2_q    <= p2_d;    norm2_q <= norm2_d;
            v3_q    <= v3_d;    float_q <= float_d; ovf_q   <= ovf_d;
`ifdef FIX2FLT_INEXACT_FLAG_EN
            inexact_q <= inexact_d;
`endif
        end
    end

    assign bus.IN_READY  = adv;
    assign bus.OUT_VALID = v3_q;
    assign bus.FLOAT_OUT = float_q;
    assign bus.OVF       = ovf_q;
`ifdef FIX2FLT_INEXACT_FLAG_EN
    assign bus.INEXACT   = inexact_q;
`endif
endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Scoreboard bench: single-precision instance (A, with stalls and reset) and half-precision instance (B).
`timescale 1ns/1ps
module tb_fixed_to_float_pipe;
    typedef struct {
        logic [31:0] f;
        logic        ovf;
        logic        inx;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    int rdy_mode = 0;

    fixed_to_float_pipe_if #(.IW(32), .EW(8), .MW(23)) bus_a ();
    fixed_to_float_pipe_if #(.IW(32), .EW(5), .MW(10)) bus_b ();

    fixed_to_float_pipe #(.IW(32), .FB(26), .EW(8), .MW(23)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
    fixed_to_float_pipe #(.IW(32), .FB(0),  .EW(5), .MW(10)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value = x / 2^fb, rounded to nearest-even at mw fraction bits via integer remainder
    function automatic exp_t model(logic [31:0] x, int fb, int ew, int mw);
        exp_t r;
        longint v, mag, q, rem, half;
        int p, sh, e;
        bit s;
        r.f = '0; r.ovf = 1'b0; r.inx = 1'b0; r.acc_cyc = 0; r.chk_lat = 0;
        v = longint'($signed(x));
        s = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return r;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= mw) begin
            q = mag << (mw - p);
        end else begin
            sh   = p - mw;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            r.inx = (rem != 0);
        end
        if (q == (longint'(1) << (mw + 1))) begin
            q = q >> 1;
            p++;
        end
        e = p - fb + (1 << (ew - 1)) - 1;
        if (e >= (1 << ew) - 1) begin
            r.f   = 32'((longint'(s) << (ew + mw)) | (((longint'(1) << ew) - 1) << mw));
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else if (e <= 0) begin
            r.f   = 32'(longint'(s) << (ew + mw));
            r.inx = 1'b1;
        end else begin
            r.f = 32'((longint'(s) << (ew + mw)) | (longint'(e) << mw) | (q - (longint'(1) << mw)));
        end
        return r;
    endfunction

    always begin
        @(posedge CLK);
        #1;
        case (rdy_mode)
            0:       bus_a.OUT_READY = 1'b1;
            1:       bus_a.OUT_READY = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus_a.OUT_READY = ($urandom_range(0, 2) != 0);
        endcase
    end

    bit          stall_a = 0;
    logic [31:0] held_a;

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            stall_a = 0;
        end else begin
            chk("in_ready_a", 32'(bus_a.IN_READY), 32'(!(bus_a.OUT_VALID && !bus_a.OUT_READY)));
            if (stall_a) begin
                chk("hold_valid_a", 32'(bus_a.OUT_VALID), 32'd1);
                chk("hold_data_a", bus_a.FLOAT_OUT, held_a);
            end
            if (bus_a.OUT_VALID) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_a: got %h expected no output", bus_a.FLOAT_OUT);
                end else begin
                    e = qa[0];
                    chk("float_a", bus_a.FLOAT_OUT, e.f);
                    chk("ovf_a", 32'(bus_a.OVF), 32'(e.ovf));
`ifdef FIX2FLT_INEXACT_FLAG_EN
                    chk("inexact_a", 32'(bus_a.INEXACT), 32'(e.inx));
`endif
                    if (e.chk_lat) chk("latency_a", 32'(cyc - e.acc_cyc), 32'd3);
                    if (bus_a.OUT_READY) void'(qa.pop_front());
                end
            end
            stall_a = bus_a.OUT_VALID && !bus_a.OUT_READY;
            held_a  = bus_a.FLOAT_OUT;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && bus_b.OUT_VALID) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_b: got %h expected no output", bus_b.FLOAT_OUT);
            end else begin
                e = qb.pop_front();
                chk("float_b", 32'(bus_b.FLOAT_OUT), e.f);
                chk("ovf_b", 32'(bus_b.OVF), 32'(e.ovf));
`ifdef FIX2FLT_INEXACT_FLAG_EN
                chk("inexact_b", 32'(bus_b.INEXACT), 32'(e.inx));
`endif
                if (e.chk_lat) chk("latency_b", 32'(cyc - e.acc_cyc), 32'd3);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_a(logic [31:0] x, exp_t e, bit lat);
        int n = 0;
        bus_a.IN_VALID = 1'b1;
        bus_a.FIXED_IN = x;
        forever begin
            @(negedge CLK);
            if (bus_a.IN_READY) break;
            n++;
            if (n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout_a: got no IN_READY expected IN_READY within 200 cycles");
                break;
            end
        end
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        qa.push_back(e);
        @(posedge CLK);
        #1;
        bus_a.IN_VALID = 1'b0;
    endtask

    task automatic send_b(logic [31:0] x, exp_t e);
        int n = 0;
        bus_b.IN_VALID = 1'b1;
        bus_b.FIXED_IN = x;
        forever begin
            @(negedge CLK);
            if (bus_b.IN_READY) break;
            n++;
            if (n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout_b: got no IN_READY expected IN_READY within 200 cycles");
                break;
            end
        end
        e.acc_cyc = cyc;
        e.chk_lat = 1;
        qb.push_back(e);
        @(posedge CLK);
        #1;
        bus_b.IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", qa.size(), qb.size());
        end
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: rand_val = r;
            1: rand_val = r >> $urandom_range(0, 31);
            2: rand_val = ($urandom_range(0, 1) != 0) ? -(32'd1 << $urandom_range(0, 31)) : (32'd1 << $urandom_range(0, 31));
            default: rand_val = (r & ~32'hFF) | {24'd0, $urandom_range(0, 1) ? 8'hC0 : 8'h40};
        endcase
    endfunction

    logic [31:0] da_in [9] = '{32'h04000000, 32'hFC000000, 32'h00000000, 32'h80000000, 32'h00000001,
                               32'h7FFFFFFF, 32'h40000040, 32'h400000C0, 32'h40000041};
    logic [31:0] da_out[9] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hC2000000, 32'h32800000,
                               32'h42000000, 32'h41800000, 32'h41800002, 32'h41800001};
    logic        da_inx[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    logic [31:0] db_in [6] = '{32'h00010000, 32'h00000001, 32'hFFFFFFFF, 32'h0000FFE0, 32'h0000FFF0, 32'hFFFF0000};
    logic [31:0] db_out[6] = '{32'h7C00, 32'h3C00, 32'hBC00, 32'h7BFF, 32'h7C00, 32'hFC00};
    logic        db_ovf[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        db_inx[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [31:0] x;
        RST_N = 1'b0;
        bus_a.IN_VALID = 1'b0; bus_a.FIXED_IN = '0; bus_a.OUT_READY = 1'b1;
        bus_b.IN_VALID = 1'b0; bus_b.FIXED_IN = '0; bus_b.OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus_a.OUT_VALID), 32'd0);
        chk("rst_float_out", bus_a.FLOAT_OUT, 32'd0);
        chk("rst_ovf", 32'(bus_a.OVF), 32'd0);
`ifdef FIX2FLT_INEXACT_FLAG_EN
        chk("rst_inexact", 32'(bus_a.INEXACT), 32'd0);
`endif
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(bus_a.IN_READY), 32'd1);

        // Directed single-precision vectors, back-to-back, no stall: latency checked
        rdy_mode = 0;
        for (int i = 0; i < 9; i++) begin
            e.f = da_out[i]; e.ovf = 1'b0; e.inx = da_inx[i];
            send_a(da_in[i], e, 1);
        end
        drain();

        for (int i = 0; i < 6; i++) begin
            e.f = db_out[i]; e.ovf = db_ovf[i]; e.inx = db_inx[i];
            send_b(db_in[i], e);
        end
        drain();

        // 8-input stream with OUT_READY pattern 1,0,0,1
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            x = rand_val();
            send_a(x, model(x, 26, 8, 23), 0);
        end
        drain();

        // Randomised streams
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            x = rand_val();
            send_a(x, model(x, 26, 8, 23), 0);
        end
        for (int i = 0; i < 200; i++) begin
            x = ($urandom_range(0, 1) != 0) ? (32'($urandom) >> $urandom_range(12, 31)) : rand_val();
            send_b(x, model(x, 0, 5, 10));
        end
        drain();

        // Reset with three results in flight
        rdy_mode = 0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            x = rand_val();
            send_a(x, model(x, 26, 8, 23), 1);
        end
        chk("inflight_valid", 32'(bus_a.OUT_VALID), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("reset_async_valid", 32'(bus_a.OUT_VALID), 32'd0);
        qa.delete();
        qb.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        chk("post_reset_valid", 32'(bus_a.OUT_VALID), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
